// File: rtl/proc_core_mc_gen2_if.sv
// Instruction and data memory ports of proc_core_mc_gen2. Each port uses a req/ready handshake.
// The master modport is the core side and the slave modport is the memory side.
interface proc_core_mc_gen2_if #(
    parameter int DW   = 8,
    parameter int PC_W = 10,
    parameter int DA_W = 8
);
    logic            imem_req;
    logic [PC_W-1:0] imem_addr;
    logic [15:0]     imem_rdata;
    logic            imem_ready;
    logic            dmem_req;
    logic            dmem_we;
    logic [DA_W-1:0] dmem_addr;
    logic [DW-1:0]   dmem_wdata;
    logic [DW-1:0]   dmem_rdata;
    logic            dmem_ready;

    modport master (
        output imem_req, imem_addr, dmem_req, dmem_we, dmem_addr, dmem_wdata,
        input  imem_rdata, imem_ready, dmem_rdata, dmem_ready
    );

    modport slave (
        input  imem_req, imem_addr, dmem_req, dmem_we, dmem_addr, dmem_wdata,
        output imem_rdata, imem_ready, dmem_rdata, dmem_ready
    );
endinterface

// File: rtl/proc_core_mc_gen2.sv
// Multi-cycle fetch/execute/mem core with an 8-entry register file.
// The instruction and data ports use req/ready handshakes and tolerate wait states.
module proc_core_mc_gen2 #(
    parameter int DW   = 8,
    parameter int PC_W = 10,
    parameter int DA_W = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    proc_core_mc_gen2_if.master  bus,
    output logic                 halted,
    output logic                 retire
);
    typedef enum logic [1:0] {FETCH, EXEC, MEM, HALTED} state_t;
    typedef enum logic [3:0] {
        OP_NOP = 4'h0, OP_ADD = 4'h1, OP_SUB = 4'h2, OP_AND = 4'h3,
        OP_OR  = 4'h4, OP_XOR = 4'h5, OP_LI  = 4'h6, OP_LD  = 4'h7,
        OP_ST  = 4'h8, OP_BZ  = 4'h9, OP_JMP = 4'hA, OP_HALT = 4'hF
    } op_t;

    // Wide intermediates make zero-extension/truncation work for any parameter value.
    localparam int IXW = (DW > 8) ? DW : 8;
    localparam int PXW = (PC_W > 10) ? PC_W : 10;
    localparam int AXW = (DA_W > DW) ? DA_W : DW;

    state_t          state, state_n;
    logic [PC_W-1:0] pc, pc_n;
    logic [15:0]     ir;
    logic            ir_load;
    logic [DW-1:0]   regs [8];
    logic            wr_en;
    logic [DW-1:0]   wr_data;
    logic [DA_W-1:0] daddr, daddr_n;
    logic [DW-1:0]   dwdata, dwdata_n;
    logic            retire_n;

    op_t             op;
    logic [2:0]      rd;
    logic [DW-1:0]   rs1v, rs2v, rdv;
    logic [IXW-1:0]  imm_x;
    logic [PXW-1:0]  jt_x;
    logic [AXW-1:0]  a_x;
    logic [PC_W-1:0] boff_x;

    assign op     = op_t'(ir[15:12]);
    assign rd     = ir[11:9];
    assign rs1v   = regs[ir[8:6]];
    assign rs2v   = regs[ir[5:3]];
    assign rdv    = regs[rd];
    assign imm_x  = IXW'(ir[7:0]);
    assign jt_x   = PXW'(ir[9:0]);
    assign a_x    = AXW'(rs1v);
    assign boff_x = PC_W'($signed(ir[8:0]));

    // Gating with reset holds the fetch request low during reset.
    // The request then rises in the first cycle after reset is released.
    assign bus.imem_req   = (state == FETCH) & reset;
    assign bus.imem_addr  = pc;
    assign bus.dmem_req   = (state == MEM);
    assign bus.dmem_we    = (state == MEM) & (op == OP_ST);
    assign bus.dmem_addr  = daddr;
    assign bus.dmem_wdata = dwdata;
    assign halted         = (state == HALTED);

    always_comb begin
        state_n  = state;
        pc_n     = pc;
        ir_load  = 1'b0;
        wr_en    = 1'b0;
        wr_data  = '0;
        daddr_n  = daddr;
        dwdata_n = dwdata;
        retire_n = 1'b0;
        unique case (state)
            FETCH: begin
                if (bus.imem_ready) begin
                    ir_load = 1'b1;
                    state_n = EXEC;
                end
            end
            EXEC: begin
                state_n  = FETCH;
                retire_n = 1'b1;
                pc_n     = pc + PC_W'(1);
                case (op)
                    OP_ADD: begin wr_en = 1'b1; wr_data = rs1v + rs2v; end
                    OP_SUB: begin wr_en = 1'b1; wr_data = rs1v - rs2v; end
                    OP_AND: begin wr_en = 1'b1; wr_data = rs1v & rs2v; end
                    OP_OR:  begin wr_en = 1'b1; wr_data = rs1v | rs2v; end
                    OP_XOR: begin wr_en = 1'b1; wr_data = rs1v ^ rs2v; end
                    OP_LI:  begin wr_en = 1'b1; wr_data = imm_x[DW-1:0]; end
                    OP_LD, OP_ST: begin
                        state_n  = MEM;
                        retire_n = 1'b0;
                        pc_n     = pc;
                        daddr_n  = a_x[DA_W-1:0];
                        dwdata_n = rs2v;
                    end
                    OP_BZ:   if (rdv == '0) pc_n = pc + boff_x;
                    OP_JMP:  pc_n = jt_x[PC_W-1:0];
                    OP_HALT: begin state_n = HALTED; pc_n = pc; end
                    default: ;
                endcase
            end
            MEM: begin
                if (bus.dmem_ready) begin
                    state_n  = FETCH;
                    retire_n = 1'b1;
                    pc_n     = pc + PC_W'(1);
                    if (op == OP_LD) begin
                        wr_en   = 1'b1;
                        wr_data = bus.dmem_rdata;
                    end
                end
            end
            HALTED: ;
            default: state_n = FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= FETCH;
            pc     <= '0;
            ir     <= '0;
            daddr  <= '0;
            dwdata <= '0;
            retire <= 1'b0;
            for (int unsigned i = 0; i < 8; i++) regs[i] <= '0;
        end else begin
            state  <= state_n;
            pc     <= pc_n;
            daddr  <= daddr_n;
            dwdata <= dwdata_n;
            retire <= retire_n;
            if (ir_load) ir <= bus.imem_rdata;
            if (wr_en) regs[rd] <= wr_data;
        end
    end
endmodule

// File: tb/tb_proc_core_mc_gen2.sv
// Bench for proc_core_mc_gen2: an instruction-level model with abstract phase timing.
// Directed programs pin the model, and randomized programs run with random wait states.
module tb_proc_core_mc_gen2;
    localparam int DW = 8, PC_W = 10, DA_W = 8;
    localparam int PMASK = (1 << PC_W) - 1;
    localparam int DMASK = (1 << DW) - 1;
    localparam int AMASK = (1 << DA_W) - 1;
    localparam int K_FETCH = 0, K_EXEC = 1, K_MEM = 2, K_HALT = 3;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic halted, retire;

    proc_core_mc_gen2_if #(.DW(DW), .PC_W(PC_W), .DA_W(DA_W)) bus ();
    proc_core_mc_gen2 #(.DW(DW), .PC_W(PC_W), .DA_W(DA_W)) dut (
        .clk(clk), .reset(reset), .bus(bus), .halted(halted), .retire(retire)
    );

    always #5 clk = ~clk;

    logic [15:0] prog [1024];
    int dmem [256];
    int m_pc, m_ir, kind, exp_retire, m_we, m_addr, m_wdata;
    int m_r [8];
    int m_mem [256];
    int cyc, halt_cyc, halt_seen;
    int imw, dmw, i_cnt, d_cnt;
    bit i_arm, d_arm, run;
    int rt_q[$];
    int f_q[$];
    int tests = 0, fails = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [15:0] enc_r(input logic [3:0] op, input logic [2:0] rd,
                                          input logic [2:0] rs1, input logic [2:0] rs2);
        return {op, rd, rs1, rs2, 3'b000};
    endfunction
    function automatic logic [15:0] enc_li(input logic [2:0] rd, input logic [7:0] imm);
        return {4'h6, rd, 1'b0, imm};
    endfunction
    function automatic logic [15:0] enc_ld(input logic [2:0] rd, input logic [2:0] rs1);
        return {4'h7, rd, rs1, 6'b0};
    endfunction
    function automatic logic [15:0] enc_st(input logic [2:0] rs1, input logic [2:0] rs2);
        return {4'h8, 3'b000, rs1, rs2, 3'b000};
    endfunction
    function automatic logic [15:0] enc_bz(input logic [2:0] rd, input logic [8:0] off);
        return {4'h9, rd, off};
    endfunction
    function automatic logic [15:0] enc_jmp(input logic [9:0] t);
        return {4'hA, 2'b00, t};
    endfunction

    // Executes one instruction against the architectural state of the ISA model.
    task automatic m_exec();
        int op, rd, a, b, off, nxt;
        op  = (m_ir >> 12) & 15;
        rd  = (m_ir >> 9) & 7;
        a   = m_r[(m_ir >> 6) & 7];
        b   = m_r[(m_ir >> 3) & 7];
        kind = K_FETCH;
        exp_retire = 1;
        nxt = (m_pc + 1) & PMASK;
        case (op)
            1: m_r[rd] = (a + b) & DMASK;
            2: m_r[rd] = (a - b) & DMASK;
            3: m_r[rd] = a & b;
            4: m_r[rd] = a | b;
            5: m_r[rd] = a ^ b;
            6: m_r[rd] = (m_ir & 255) & DMASK;
            7, 8: begin
                kind = K_MEM; exp_retire = 0; nxt = m_pc;
                m_we = (op == 8) ? 1 : 0; m_addr = a & AMASK; m_wdata = b;
            end
            9: if (m_r[rd] == 0) begin
                off = m_ir & 511;
                if (off >= 256) off = off - 512;
                nxt = (m_pc + off) & PMASK;
            end
            10: nxt = (m_ir & 1023) & PMASK;
            15: begin kind = K_HALT; nxt = m_pc; end
            default: ;
        endcase
        m_pc = nxt;
    endtask

    always @(negedge clk) begin
        if (run) begin
            chk("retire", retire, exp_retire);
            chk("halted", halted, kind == K_HALT);
            chk("imem_req", bus.imem_req, kind == K_FETCH);
            if (kind == K_FETCH) chk("imem_addr", bus.imem_addr, m_pc);
            chk("dmem_req", bus.dmem_req, kind == K_MEM);
            if (kind == K_MEM) begin
                chk("dmem_we", bus.dmem_we, m_we);
                chk("dmem_addr", bus.dmem_addr, m_addr);
                if (m_we != 0) chk("dmem_wdata", bus.dmem_wdata, m_wdata);
            end
            if (retire) rt_q.push_back(cyc);
            if (kind == K_HALT) begin
                if (halt_seen == 0) halt_cyc = cyc;
                halt_seen++;
            end
            // Memory side: a wait count per request; noise on ready while req is low.
            if (bus.imem_req) begin
                if (!i_arm) begin i_cnt = (imw < 0) ? $urandom_range(0, 2) : imw; i_arm = 1; end
                if (i_cnt == 0) begin bus.imem_ready = 1'b1; i_arm = 0; end
                else begin bus.imem_ready = 1'b0; i_cnt--; end
            end else bus.imem_ready = 1'($urandom_range(0, 1));
            bus.imem_rdata = prog[bus.imem_addr];
            if (bus.dmem_req) begin
                if (!d_arm) begin d_cnt = (dmw < 0) ? $urandom_range(0, 3) : dmw; d_arm = 1; end
                if (d_cnt == 0) begin bus.dmem_ready = 1'b1; d_arm = 0; end
                else begin bus.dmem_ready = 1'b0; d_cnt--; end
            end else bus.dmem_ready = 1'($urandom_range(0, 1));
            bus.dmem_rdata = DW'(dmem[bus.dmem_addr]);
            if (bus.dmem_req && bus.dmem_ready && bus.dmem_we)
                dmem[bus.dmem_addr] = int'(bus.dmem_wdata);
            exp_retire = 0;
            case (kind)
                K_FETCH: if (bus.imem_ready) begin
                    m_ir = int'(prog[m_pc]); f_q.push_back(m_pc); kind = K_EXEC;
                end
                K_EXEC: m_exec();
                K_MEM: if (bus.dmem_ready) begin
                    if (m_we != 0) m_mem[m_addr] = m_wdata;
                    else m_r[(m_ir >> 9) & 7] = m_mem[m_addr];
                    m_pc = (m_pc + 1) & PMASK; exp_retire = 1; kind = K_FETCH;
                end
                default: ;
            endcase
            cyc++;
        end
    end

    task automatic clear_prog();
        for (int i = 0; i < 1024; i++) prog[i] = 16'hF000;
    endtask

    task automatic start(input int iw, input int dw);
        run = 0; reset = 1'b0;
        bus.imem_ready = 1'b0; bus.dmem_ready = 1'b0;
        @(posedge clk);
        imw = iw; dmw = dw; i_arm = 0; d_arm = 0;
        m_pc = 0; kind = K_FETCH; exp_retire = 0;
        for (int i = 0; i < 8; i++) m_r[i] = 0;
        for (int i = 0; i < 256; i++) m_mem[i] = dmem[i];
        cyc = 0; halt_seen = 0; halt_cyc = -1;
        rt_q.delete(); f_q.delete();
        @(posedge clk);
        #2 reset = 1'b1; run = 1;
    endtask

    task automatic finish_prog(input string name, input int budget);
        int n;
        n = 0;
        while (halt_seen < 2 && n < budget) begin @(posedge clk); n++; end
        tests++;
        if (halt_seen < 2) begin
            fails++;
            $display("FAIL %s timeout: no halt within %0d cycles, expected halt", name, budget);
        end
        run = 0;
    endtask

    initial begin
        int n, L, sel, off;
        logic [15:0] w;
        int exp_f[10];
        bus.imem_ready = 1'b0; bus.dmem_ready = 1'b0;
        bus.imem_rdata = '0; bus.dmem_rdata = '0;
        for (int i = 0; i < 256; i++) dmem[i] = 0;
        #1 chk("reset imem_req", bus.imem_req, 0);
        chk("reset dmem_req", bus.dmem_req, 0);
        chk("reset halted", halted, 0);

        // LI/LI/ADD/HALT at zero wait states.
        clear_prog();
        prog[0] = enc_li(3'd1, 8'd5); prog[1] = enc_li(3'd2, 8'd3);
        prog[2] = enc_r(4'h1, 3'd3, 3'd1, 3'd2); prog[3] = 16'hF000;
        start(0, 0); finish_prog("p1", 200);
        chk("p1 halt cycle", halt_cyc, 8);
        chk("p1 retire count", rt_q.size(), 4);
        chk("p1 model R3", m_r[3], 8);
        chk("p1 pc frozen", bus.imem_addr, 3);

        // Wrapping arithmetic, with results stored out for observation.
        clear_prog();
        dmem[0] = 'hEE; dmem[1] = 'hEE;
        prog[0] = enc_li(3'd1, 8'hFF); prog[1] = enc_li(3'd2, 8'h02);
        prog[2] = enc_r(4'h1, 3'd3, 3'd1, 3'd2); prog[3] = enc_r(4'h2, 3'd4, 3'd2, 3'd1);
        prog[4] = enc_st(3'd0, 3'd3); prog[5] = enc_li(3'd0, 8'd1);
        prog[6] = enc_st(3'd0, 3'd4); prog[7] = 16'hF000;
        start(-1, -1); finish_prog("p2", 400);
        chk("p2 add wrap", dmem[0], 'h01);
        chk("p2 sub wrap", dmem[1], 'h03);
        chk("p2 model R4", m_r[4], 3);

        // ST then LD with three data wait states each.
        clear_prog();
        prog[0] = enc_li(3'd1, 8'h10); prog[1] = enc_li(3'd2, 8'h5A);
        prog[2] = enc_st(3'd1, 3'd2); prog[3] = enc_ld(3'd5, 3'd1);
        prog[4] = enc_li(3'd0, 8'h20); prog[5] = enc_st(3'd0, 3'd5); prog[6] = 16'hF000;
        start(0, 3); finish_prog("p3", 400);
        chk("p3 retire count", rt_q.size(), 7);
        if (rt_q.size() >= 4) begin
            chk("p3 st cycles", rt_q[2] - rt_q[1], 6);
            chk("p3 ld cycles", rt_q[3] - rt_q[2], 6);
        end
        chk("p3 ld value", dmem['h20], 'h5A);

        // Taken/not-taken branches and a jump that wraps the pc.
        clear_prog();
        prog[0] = enc_bz(3'd0, 9'd3); prog[1] = 16'hF000; prog[2] = enc_li(3'd0, 8'd1);
        prog[3] = 16'h0000; prog[4] = enc_bz(3'd0, 9'h1FE); prog[5] = enc_jmp(10'h3FF);
        prog[1023] = 16'h0000;
        start(-1, -1); finish_prog("p4", 400);
        exp_f = '{0, 3, 4, 2, 3, 4, 5, 'h3FF, 0, 1};
        chk("p4 fetch count", f_q.size(), 10);
        if (f_q.size() == 10)
            for (int i = 0; i < 10; i++) chk($sformatf("p4 fetch[%0d]", i), f_q[i], exp_f[i]);

        // Five-cycle instruction stall.
        clear_prog();
        prog[0] = enc_li(3'd1, 8'd7);
        start(5, 0); finish_prog("p5", 200);
        chk("p5 retire count", rt_q.size(), 2);
        if (rt_q.size() > 0) chk("p5 first retire", rt_q[0], 7);

        // Reset during the MEM phase of a load.
        clear_prog();
        prog[0] = enc_li(3'd1, 8'h10); prog[1] = enc_ld(3'd6, 3'd1);
        start(0, 1000);
        n = 0;
        while (kind != K_MEM && n < 50) begin @(posedge clk); n++; end
        #1 chk("p6 dmem_req in MEM", bus.dmem_req, 1);
        run = 0;
        #1 reset = 1'b0;
        #1 chk("p6 dmem_req on reset", bus.dmem_req, 0);
        chk("p6 imem_req on reset", bus.imem_req, 0);
        clear_prog();
        dmem[0] = 'hAB;
        prog[0] = enc_st(3'd0, 3'd6);
        start(0, 0); finish_prog("p6", 200);
        chk("p6 R6 unwritten", dmem[0], 0);
        chk("p6 fetch count", f_q.size(), 2);
        if (f_q.size() > 0) chk("p6 first fetch", f_q[0], 0);

        // Randomized forward-only programs, with the registers dumped by stores.
        for (int p = 0; p < 15; p++) begin
            clear_prog();
            L = 24;
            for (int i = 0; i < 256; i++) dmem[i] = $urandom_range(0, 255);
            for (int i = 0; i < L; i++) begin
                w = 16'($urandom);
                sel = $urandom_range(0, 9);
                if (sel <= 3) w[15:12] = 4'($urandom_range(1, 5));
                else if (sel == 4) w[15:12] = 4'h6;
                else if (sel == 5) w[15:12] = 4'h7;
                else if (sel == 6) w[15:12] = 4'h8;
                else if (sel == 7) begin
                    off = $urandom_range(1, 3);
                    if (i + off > L) off = L - i;
                    w = {4'h9, w[11:9], 9'(off)};
                end else if (sel == 8) begin
                    off = $urandom_range(1, 3);
                    if (i + off > L) off = L - i;
                    w = {4'hA, 2'b00, 10'(i + off)};
                end else w[15:12] = 4'($urandom_range(11, 14));
                prog[i] = w;
            end
            for (int r = 0; r < 8; r++) prog[L + r] = enc_st(3'(r), 3'(r));
            prog[L + 8] = 16'hF000;
            start(-1, -1);
            finish_prog($sformatf("rand%0d", p), 3000);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/proc_core_mc_gen2.md
Name: proc_core_mc_gen2

Overview:
- Parametrised multi-cycle successor to the single-generation processor top.
- Integrates the fetch/decode/execute FSM and an 8-entry register file in one block.
- Has separate instruction and data memory ports, each using a req/ready handshake, so memory can insert wait states.
- Adds data width and address width parameters, wait-state tolerance, branches, HALT, and a retire strobe.

Parameters:
- DW, 8: data/register width in bits (DW >= 2).
- PC_W, 10: program counter and instruction address width (PC_W >= 9).
- DA_W, 8: data memory address width.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- imem_req  out  1  instruction fetch request.
- imem_addr  out  PC_W  fetch address (equals pc).
- imem_rdata  in  16  instruction word.
- imem_ready  in  1  fetch data valid / accept.
- dmem_req  out  1  data access request.
- dmem_we  out  1  1 = store, 0 = load.
- dmem_addr  out  DA_W  data address.
- dmem_wdata  out  DW  store data.
- dmem_rdata  in  DW  load data.
- dmem_ready  in  1  data access complete.
- halted  out  1  core stopped on HALT.
- retire  out  1  one-cycle pulse per completed instruction.

Behaviour:
- Instruction fields: op = ir[15:12], rd = ir[11:9], rs1 = ir[8:6], rs2 = ir[5:3], imm8 = ir[7:0], boff = ir[8:0] (signed), jtgt = ir[9:0].
- Opcodes:
  - 0 NOP.
  - 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR: rd = rs1 op rs2.
  - 6 LI: rd = imm8, zero-extended or truncated to DW.
  - 7 LD: rd = mem[R[rs1]].
  - 8 ST: mem[R[rs1]] = R[rs2].
  - 9 BZ: if R[rd] == 0 then pc = pc + sext(boff), else pc + 1.
  - A JMP: pc = jtgt, zero-extended or truncated to PC_W.
  - F HALT.
  - B–E are executed as NOP.
- Arithmetic is modulo 2^DW. pc arithmetic is modulo 2^PC_W; pc + 1 wraps from all-ones to 0. dmem_addr = R[rs1] zero-extended or truncated to DA_W.
- Registers R0..R7 are all general purpose; R0 is not hardwired to zero.
- FSM states:
  - FETCH: imem_req=1, imem_addr=pc. A handshake occurs at a posedge with imem_req & imem_ready: ir <= imem_rdata, go to EXEC. Otherwise stay in FETCH, holding addr stable.
  - EXEC:
    - ALU/LI/NOP/undefined: write rd (where applicable), pc += 1, retire=1 next cycle, go to FETCH.
    - BZ/JMP: update pc, retire, go to FETCH.
    - LD/ST: go to MEM.
    - HALT: go to HALTED, retire, pc unchanged.
  - MEM: dmem_req=1, dmem_we=(op==ST), and addr/wdata held stable. On dmem_ready: a LD writes rd from dmem_rdata; pc += 1; retire; go to FETCH.
  - HALTED: halted=1, no requests; leaves only via reset.
- Timing:
  - Minimum 2 cycles per non-memory instruction and 3 per LD/ST at zero wait states.
  - Each wait cycle adds 1.
  - ready may be asserted in the same cycle as req.
- Requests are never withdrawn before ready. ready while req is low is ignored.
- retire is registered: high for exactly the cycle after the completing edge.
- Reset (asynchronous assert, synchronous deassert by the system):
  - state = FETCH, pc = 0, ir = 0, all R = 0.
  - halted, retire, imem_req, dmem_req, dmem_we are 0; dmem_addr and dmem_wdata are 0.
  - Reset mid-handshake drops req immediately; the pending access is abandoned and no register is written.
- imem_req first rises in the first cycle after reset deasserts, with imem_addr=0.
- Register write occurs only on the completing edge; read-after-write in the next instruction sees the new value.

Test Plan:
- LI R1,5 ; LI R2,3 ; ADD R3,R1,R2 ; HALT, zero wait -> R3=8, halted=1 at cycle 8, 4 retire pulses, pc frozen at 3.
- DW=8: LI R1,0xFF ; LI R2,0x02 ; ADD R3,R1,R2 ; SUB R4,R2,R1 -> R3=0x01, R4=0x03 (wrap).
- ST mem[R1=0x10]=R2(0x5A) then LD R5,[R1] with dmem_ready delayed 3 cycles each -> dmem_req held high 4 cycles each, addr=0x10 stable, R5=0x5A, each instruction takes 6 cycles.
- BZ R0,-2 at pc=4 with R0=0 -> next fetch addr 2; with R0=1 -> addr 5. JMP 0x3FF then NOP -> fetch 0x3FF, then 0x000.
- imem_ready held low 5 cycles -> FETCH stalls, imem_addr constant, no retire.
- reset pulsed low during MEM of LD R6 -> dmem_req falls immediately, R6 stays 0, next fetch at addr 0.
